// File: rtl/pipe_acc_adder_pkg.sv
// Shared definitions for the pipelined adder/accumulator: operation encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_acc_adder_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_ACC  = 2'b01,
        MODE_SUB  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    // ACC and LOAD are the only operations that write the accumulator.
    function automatic logic writes_acc(input mode_t m);
        return (m == MODE_ACC) || (m == MODE_LOAD);
    endfunction

endpackage

// File: rtl/pipe_acc_adder_sat_clamp.sv
// Range check and optional clamp of an OUT_W+1 bit result down to OUT_W bits.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module sat_clamp #(
    parameter int OUT_W  = 16,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic [OUT_W:0]   res_i,
    input  logic             sub_i,
    output logic [OUT_W-1:0] out_o,
    output logic             ovf_o
);

    localparam logic [OUT_W-1:0] S_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] S_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] U_MAX = {OUT_W{1'b1}};

    logic [OUT_W-1:0] clamp_val;

    // Signed: out of range when the two top bits disagree; the top bit gives the direction.
    // Unsigned: the extra bit is a carry (add/acc, clamp high) or a borrow (sub, clamp to zero).
    always_comb begin
        ovf_o     = 1'b0;
        clamp_val = '0;
        if (SIGNED != 0) begin
            ovf_o     = res_i[OUT_W] ^ res_i[OUT_W-1];
            clamp_val = res_i[OUT_W] ? S_MIN : S_MAX;
        end else begin
            ovf_o     = res_i[OUT_W];
            clamp_val = sub_i ? '0 : U_MAX;
        end
        out_o = (ovf_o && (SAT != 0)) ? clamp_val : res_i[OUT_W-1:0];
    end

endmodule

// File: rtl/pipe_acc_adder.sv
// Two-stage add/sub/accumulate pipeline with valid/ready on both sides and optional saturation.
// Latency: 2 clk edges from input transfer to out_valid; 1 op per cycle sustained.
// Backpressure: stage 2 holds while out_valid && !out_ready; in_ready drops once stage 1 is also full.
module pipe_acc_adder
    import pipe_acc_adder_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 16,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic             clk,
    input  logic             sclrn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  ina,
    input  logic [IN_W-1:0]  inb,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             ovf
);

    localparam int XW = OUT_W + 1;

    // Stage 1: captured operands, already extended to the arithmetic width
    logic          s1_valid_q, s1_valid_d;
    logic [XW-1:0] s1_a_q, s1_a_d;
    logic [XW-1:0] s1_b_q, s1_b_d;
    mode_t         s1_mode_q, s1_mode_d;

    // Stage 2: result register and the accumulator
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic [OUT_W-1:0] acc_q, acc_d;

    logic             adv;
    logic             in_xfer;
    logic [XW-1:0]    ina_x, inb_x, acc_x, raw_res;
    logic [OUT_W-1:0] clamp_res;
    logic             clamp_ovf;

    // Stage 2 may load whenever its current beat is gone or leaving this cycle.
    assign adv      = !out_valid_q || out_ready;
    // Held low during reset; otherwise independent of in_valid.
    assign in_ready = sclrn && (!s1_valid_q || adv);
    assign in_xfer  = in_valid && in_ready;

    // Widen operands and accumulator to OUT_W+1 bits in the selected signedness.
    always_comb begin
        if (SIGNED != 0) begin
            ina_x = {{(XW-IN_W){ina[IN_W-1]}}, ina};
            inb_x = {{(XW-IN_W){inb[IN_W-1]}}, inb};
            acc_x = {acc_q[OUT_W-1], acc_q};
        end else begin
            ina_x = {{(XW-IN_W){1'b0}}, ina};
            inb_x = {{(XW-IN_W){1'b0}}, inb};
            acc_x = {1'b0, acc_q};
        end
    end

    // Unclamped result of the operation held in stage 1.
    always_comb begin
        raw_res = s1_a_q + s1_b_q;
        case (s1_mode_q)
            MODE_ACC: raw_res = acc_x + s1_a_q + s1_b_q;
            MODE_SUB: raw_res = s1_a_q - s1_b_q;
            default:  raw_res = s1_a_q + s1_b_q;
        endcase
    end

    sat_clamp #(
        .OUT_W  (OUT_W),
        .SIGNED (SIGNED),
        .SAT    (SAT)
    ) u_sat_clamp (
        .res_i (raw_res),
        .sub_i (s1_mode_q == MODE_SUB),
        .out_o (clamp_res),
        .ovf_o (clamp_ovf)
    );

    // Stage 1 next state: capture on input transfer, empty once its beat moves on.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_mode_d  = s1_mode_q;
        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_a_d     = ina_x;
            s1_b_d     = inb_x;
            s1_mode_d  = mode_t'(mode);
        end else if (adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 2 next state: the accumulator only changes when its beat is loaded here,
    // so back-to-back ACC ops see each other's results in program order.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        ovf_d       = ovf_q;
        acc_d       = acc_q;
        if (adv) begin
            if (s1_valid_q) begin
                out_valid_d = 1'b1;
                out_d       = clamp_res;
                ovf_d       = clamp_ovf;
                if (writes_acc(s1_mode_q)) begin
                    acc_d = clamp_res;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // All pipeline state, cleared immediately on reset assertion.
    always_ff @(posedge clk or negedge sclrn) begin
        if (!sclrn) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_mode_q   <= MODE_ADD;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            ovf_q       <= ovf_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign ovf       = ovf_q;

endmodule
